// File: rtl/keylock_pkg.sv
// Shared key codes, FSM state encoding and small helpers for the keypad lock.
package keylock_pkg;

  localparam logic [3:0] KEY_STAR    = 4'd10;
  localparam logic [3:0] KEY_HASH    = 4'd11;
  localparam logic [3:0] KEY_DIG_MAX = 4'd9;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_PROG_SLOT,
    ST_PROG_NEW,
    ST_PROG_CONFIRM,
    ST_LOCKOUT
  } state_e;

  // $clog2 that never yields a zero-width vector for tiny parameters
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keylock_code_store.sv
// Programmable user-code slots with valid bits and a combinational any-match
// against the entry buffer. Invalid slots never match.
module keylock_code_store
  import keylock_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int NUM_SLOTS = 4,
  localparam int IDX_W    = clog2_min1(NUM_SLOTS),
  localparam int CODE_W   = DIGITS * 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              wr_set_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [CODE_W-1:0] wr_data_i,
  input  logic [CODE_W-1:0] cmp_data_i,
  output logic              match_o
);

  logic [CODE_W-1:0]    slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (wr_en_i && (wr_idx_i == IDX_W'(s))) vld_q[s] <= wr_set_i;
      end
    end
  end

  // Slot contents are data only; the valid bits decide whether they count.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (wr_en_i && wr_set_i && (wr_idx_i == IDX_W'(s))) slot_q[s] <= wr_data_i;
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (vld_q[s] && (slot_q[s] == cmp_data_i)) match_o = 1'b1;
    end
  end

endmodule

// File: rtl/keylock_ctrl.sv
// Keypad lock controller: BCD entry buffer, master/user code check, slot
// programming with confirmation, failed-attempt lockout and inactivity timeout.
module keylock_ctrl
  import keylock_pkg::*;
#(
  parameter int                  DIGITS         = 6,
  parameter int                  NUM_SLOTS      = 4,
  parameter logic [DIGITS*4-1:0] MASTER_CODE    = 'h555116,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 36_000_000,
  parameter int                  TIMEOUT_CYCLES = 120_000_000,
  localparam int                 FAIL_W         = $clog2(MAX_FAILS + 1)
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic [3:0]        key,
  input  logic              key_valid,
  output logic              locked,
  output logic              unlock_evt,
  output logic              error_evt,
  output logic              prog_ok_evt,
  output logic              lockout,
  output logic              prog_mode,
  output logic [FAIL_W-1:0] fail_count,
  output logic              busy
);

  localparam int CODE_W = DIGITS * 4;
  localparam int CNT_W  = $clog2(DIGITS + 2);
  localparam int IDX_W  = clog2_min1(NUM_SLOTS);
  localparam int LCK_W  = clog2_min1(LOCKOUT_CYCLES);
  localparam int TMO_W  = clog2_min1(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DIGITS + 1);
  localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovl_q, ovl_d;
  logic                locked_q, locked_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [IDX_W-1:0]    slot_q, slot_d;
  logic [CODE_W-1:0]   cand_q, cand_d;
  logic [LCK_W-1:0]    lck_q, lck_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                unlock_q, unlock_d;
  logic                err_q, err_d;
  logic                prog_q, prog_d;

  logic                wr_en, wr_set, slot_match;
  logic                push, clr;
  logic                is_digit, is_star, is_hash;
  logic                code_full, code_ok, in_timed, fail_reach;
  logic [CODE_W-1:0]   sh_buf;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + 1'b1;
  endfunction

  keylock_code_store #(
    .DIGITS   (DIGITS),
    .NUM_SLOTS(NUM_SLOTS)
  ) u_store (
    .clk_i     (hwclk),
    .rst_i     (reset),
    .wr_en_i   (wr_en),
    .wr_set_i  (wr_set),
    .wr_idx_i  (slot_q),
    .wr_data_i (buf_q),
    .cmp_data_i(buf_q),
    .match_o   (slot_match)
  );

  assign is_digit   = key_valid && (key <= KEY_DIG_MAX);
  assign is_star    = key_valid && (key == KEY_STAR);
  assign is_hash    = key_valid && (key == KEY_HASH);
  assign sh_buf     = {buf_q[CODE_W-5:0], bcd_t'(key)};
  assign code_full  = (cnt_q == CNT_FULL) && !ovl_q;
  assign code_ok    = code_full && ((buf_q == MASTER_CODE) || slot_match);
  assign in_timed   = (state_q == ST_ENTRY) || (state_q == ST_PROG_SLOT) ||
                      (state_q == ST_PROG_NEW) || (state_q == ST_PROG_CONFIRM);
  assign fail_reach = (int'(fail_q) + 1) >= MAX_FAILS;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    ovl_d    = ovl_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    slot_d   = slot_q;
    cand_d   = cand_q;
    lck_d    = (lck_q != '0) ? lck_q - 1'b1 : lck_q;
    tmo_d    = (key_valid || !in_timed) ? TMO_LOAD :
               ((tmo_q != '0) ? tmo_q - 1'b1 : tmo_q);
    unlock_d = 1'b0;
    err_d    = 1'b0;
    prog_d   = 1'b0;
    wr_en    = 1'b0;
    wr_set   = 1'b0;
    push     = 1'b0;
    clr      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (is_digit) begin
          state_d = ST_ENTRY;
          push    = 1'b1;
        end else if (is_star) begin
          if (locked_q) err_d = 1'b1;
          else          state_d = ST_PROG_SLOT;
        end
      end

      ST_ENTRY: begin
        if (is_digit) begin
          push = 1'b1;
        end else if (is_hash) begin
          if (code_ok) begin
            locked_d = !locked_q;
            unlock_d = 1'b1;
            fail_d   = '0;
            state_d  = ST_IDLE;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_q + 1'b1;
            if (fail_reach) begin
              state_d = ST_LOCKOUT;
              lck_d   = LCK_LOAD;
              clr     = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (is_star) begin
          state_d = ST_IDLE;
        end
      end

      ST_PROG_SLOT: begin
        if (is_digit) begin
          if (int'(key) < NUM_SLOTS) begin
            slot_d  = IDX_W'(key);
            state_d = ST_PROG_NEW;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (is_hash) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (is_star) begin
          state_d = ST_IDLE;
        end
      end

      ST_PROG_NEW: begin
        if (is_digit) begin
          push = 1'b1;
        end else if (is_hash) begin
          if (cnt_q == '0) begin
            wr_en   = 1'b1;
            prog_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (code_full) begin
            cand_d  = buf_q;
            clr     = 1'b1;
            state_d = ST_PROG_CONFIRM;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (is_star) begin
          state_d = ST_IDLE;
        end
      end

      ST_PROG_CONFIRM: begin
        if (is_digit) begin
          push = 1'b1;
        end else if (is_hash) begin
          if (code_full && (buf_q == cand_q)) begin
            wr_en  = 1'b1;
            wr_set = 1'b1;
            prog_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (is_star) begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        // Keys are ignored here, including one arriving on the expiry cycle.
        if (lck_q == '0) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A key in the expiry cycle already reloaded the timer, so it wins.
    if (in_timed && !key_valid && (tmo_q == '0)) state_d = ST_IDLE;

    if (push) begin
      buf_d = sh_buf;
      cnt_d = sat_inc(cnt_q);
      ovl_d = ovl_q || (cnt_q >= CNT_FULL);
    end

    if (clr || (state_d == ST_IDLE)) begin
      buf_d = '0;
      cnt_d = '0;
      ovl_d = 1'b0;
    end
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      ovl_q    <= 1'b0;
      locked_q <= 1'b1;
      fail_q   <= '0;
      unlock_q <= 1'b0;
      err_q    <= 1'b0;
      prog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      ovl_q    <= ovl_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
      unlock_q <= unlock_d;
      err_q    <= err_d;
      prog_q   <= prog_d;
    end
  end

  always_ff @(posedge hwclk) begin
    slot_q <= slot_d;
    cand_q <= cand_d;
    lck_q  <= lck_d;
    tmo_q  <= tmo_d;
  end

  assign locked      = locked_q;
  assign unlock_evt  = unlock_q;
  assign error_evt   = err_q;
  assign prog_ok_evt = prog_q;
  assign fail_count  = fail_q;
  assign lockout     = (state_q == ST_LOCKOUT);
  assign prog_mode   = (state_q == ST_PROG_SLOT) || (state_q == ST_PROG_NEW) ||
                       (state_q == ST_PROG_CONFIRM);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_keylock_ctrl.sv
// Bench for keylock_ctrl: digit-queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_keylock_ctrl;

  localparam int DIGITS    = 6;
  localparam int NUM_SLOTS = 4;
  localparam int MAX_FAILS = 3;
  localparam int LOCK_CYC  = 40;
  localparam int TMO_CYC   = 60;
  localparam logic [23:0] MASTER = 24'h555116;
  localparam int FAIL_W    = $clog2(MAX_FAILS + 1);

  logic              hwclk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        key = 4'd0;
  logic              key_valid = 1'b0;
  logic              locked, unlock_evt, error_evt, prog_ok_evt, lockout, prog_mode, busy;
  logic [FAIL_W-1:0] fail_count;

  keylock_ctrl #(
    .DIGITS        (DIGITS),
    .NUM_SLOTS     (NUM_SLOTS),
    .MASTER_CODE   (MASTER),
    .MAX_FAILS     (MAX_FAILS),
    .LOCKOUT_CYCLES(LOCK_CYC),
    .TIMEOUT_CYCLES(TMO_CYC)
  ) dut (
    .hwclk      (hwclk),
    .reset      (reset),
    .key        (key),
    .key_valid  (key_valid),
    .locked     (locked),
    .unlock_evt (unlock_evt),
    .error_evt  (error_evt),
    .prog_ok_evt(prog_ok_evt),
    .lockout    (lockout),
    .prog_mode  (prog_mode),
    .fail_count (fail_count),
    .busy       (busy)
  );

  always #5 hwclk = ~hwclk;

  int n_tests = 0;
  int n_fails = 0;
  int n_unl = 0, n_err = 0, n_prog = 0;
  bit started = 0;

  // Reference model: entry kept as a queue of digits, codes as digit arrays.
  localparam int MI = 0, ME = 1, MS = 2, MN = 3, MC = 4, ML = 5;
  int m_mode, m_locked, m_fail, m_idle, m_lock_el, m_slot;
  int ent[$];
  int cand[DIGITS];
  int slot_code[NUM_SLOTS][DIGITS];
  bit slot_vld[NUM_SLOTS];
  int e_unl, e_err, e_prog;

  function automatic int mdig(input int i);
    logic [23:0] m;
    m = MASTER >> (4 * (DIGITS - 1 - i));
    return int'(m[3:0]);
  endfunction

  function automatic bit code_ok();
    bit hit;
    if (ent.size() != DIGITS) return 0;
    hit = 1;
    for (int i = 0; i < DIGITS; i++) if (ent[i] != mdig(i)) hit = 0;
    if (hit) return 1;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slot_vld[s]) begin
        hit = 1;
        for (int i = 0; i < DIGITS; i++) if (ent[i] != slot_code[s][i]) hit = 0;
        if (hit) return 1;
      end
    end
    return 0;
  endfunction

  function automatic bit cand_ok();
    if (ent.size() != DIGITS) return 0;
    for (int i = 0; i < DIGITS; i++) if (ent[i] != cand[i]) return 0;
    return 1;
  endfunction

  task automatic go_idle();
    m_mode = MI;
    ent.delete();
  endtask

  task automatic model_step(input bit rst, input bit v, input int k);
    int pre;
    bit dig, star, hash;
    e_unl = 0; e_err = 0; e_prog = 0;
    if (rst) begin
      go_idle();
      m_locked = 1; m_fail = 0; m_idle = 0; m_lock_el = 0;
      for (int s = 0; s < NUM_SLOTS; s++) slot_vld[s] = 0;
      return;
    end
    pre  = m_mode;
    dig  = v && (k <= 9);
    star = v && (k == 10);
    hash = v && (k == 11);
    case (pre)
      MI: begin
        if (dig) begin ent.delete(); ent.push_back(k); m_mode = ME; end
        else if (star) begin if (m_locked != 0) e_err = 1; else m_mode = MS; end
      end
      ME: begin
        if (dig) ent.push_back(k);
        else if (hash) begin
          if (code_ok()) begin
            m_locked = (m_locked != 0) ? 0 : 1; e_unl = 1; m_fail = 0; go_idle();
          end else begin
            e_err = 1; m_fail++;
            if (m_fail >= MAX_FAILS) begin m_mode = ML; ent.delete(); m_lock_el = 0; end
            else go_idle();
          end
        end else if (star) go_idle();
      end
      MS: begin
        if (dig) begin
          if (k < NUM_SLOTS) begin m_slot = k; m_mode = MN; end
          else begin e_err = 1; go_idle(); end
        end else if (hash) begin e_err = 1; go_idle(); end
        else if (star) go_idle();
      end
      MN: begin
        if (dig) ent.push_back(k);
        else if (hash) begin
          if (ent.size() == 0) begin slot_vld[m_slot] = 0; e_prog = 1; go_idle(); end
          else if (ent.size() == DIGITS) begin
            for (int i = 0; i < DIGITS; i++) cand[i] = ent[i];
            ent.delete(); m_mode = MC;
          end else begin e_err = 1; go_idle(); end
        end else if (star) go_idle();
      end
      MC: begin
        if (dig) ent.push_back(k);
        else if (hash) begin
          if (cand_ok()) begin
            for (int i = 0; i < DIGITS; i++) slot_code[m_slot][i] = cand[i];
            slot_vld[m_slot] = 1; e_prog = 1;
          end else e_err = 1;
          go_idle();
        end else if (star) go_idle();
      end
      ML: begin
        m_lock_el++;
        if (m_lock_el >= LOCK_CYC) begin m_fail = 0; go_idle(); end
      end
      default: go_idle();
    endcase
    if (pre == ME || pre == MS || pre == MN || pre == MC) begin
      if (v) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle >= TMO_CYC) go_idle();
      end
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cyc();
    @(posedge hwclk);
    model_step(reset, key_valid, int'(key));
    started = 1;
    @(negedge hwclk);
    if (started) begin
      check("locked",      int'(locked),      m_locked);
      check("unlock_evt",  int'(unlock_evt),  e_unl);
      check("error_evt",   int'(error_evt),   e_err);
      check("prog_ok_evt", int'(prog_ok_evt), e_prog);
      check("lockout",     int'(lockout),     (m_mode == ML) ? 1 : 0);
      check("prog_mode",   int'(prog_mode),   (m_mode == MS || m_mode == MN || m_mode == MC) ? 1 : 0);
      check("busy",        int'(busy),        (m_mode != MI) ? 1 : 0);
      check("fail_count",  int'(fail_count),  m_fail);
    end
    if (unlock_evt)  n_unl++;
    if (error_evt)   n_err++;
    if (prog_ok_evt) n_prog++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press(input int k, input int gap);
    key = 4'(k);
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      int  k;
      c = s[i];
      if (c == "*")      k = 10;
      else if (c == "#") k = 11;
      else               k = int'(c) - 48;
      press(k, gap);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  function automatic string rand_code();
    case ($urandom_range(0, 2))
      0:       return "666666";
      1:       return "111111";
      default: return "123456";
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int u0, e0, p0;
    do_reset(2);
    idle(1);
    check("rst_locked", int'(locked), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_fail", int'(fail_count), 0);
    check("rst_lockout", int'(lockout), 0);

    // master code unlocks
    send("555116#", 1);
    check("unlock_cnt", n_unl, 1);
    check("unlocked", int'(locked), 0);
    check("unlock_fail", int'(fail_count), 0);

    // three wrong codes while locked -> lockout, keys ignored, then recover
    send("555116#", 1);
    check("relocked", int'(locked), 1);
    e0 = n_err; u0 = n_unl;
    send("123456#", 1);
    send("123456#", 1);
    send("123456#", 1);
    check("wrong_err_cnt", n_err - e0, 3);
    check("lockout_hi", int'(lockout), 1);
    check("lockout_fail", int'(fail_count), 3);
    send("555116#", 1);
    check("lockout_ignored", n_unl - u0, 0);
    check("lockout_still_locked", int'(locked), 1);
    idle(LOCK_CYC);
    check("lockout_done", int'(lockout), 0);
    check("lockout_fail_clr", int'(fail_count), 0);

    // program slot 2 with 666666 and use it
    send("555116#", 1);
    p0 = n_prog;
    send("*2666666#666666#", 1);
    check("prog_ok_cnt", n_prog - p0, 1);
    send("555116#", 1);
    u0 = n_unl;
    send("666666#", 1);
    check("slot_unlock", n_unl - u0, 1);
    check("slot_unlocked", int'(locked), 0);

    // confirm mismatch leaves slot 1 invalid; bad slot index rejected
    e0 = n_err;
    send("*1111111#111112#", 1);
    check("confirm_mismatch_err", n_err - e0, 1);
    send("555116#", 1);
    send("111111#", 1);
    check("slot1_invalid_locked", int'(locked), 1);
    check("slot1_invalid_fail", int'(fail_count), 1);
    send("555116#", 1);
    e0 = n_err;
    send("*7", 1);
    check("bad_slot_err", n_err - e0, 1);
    check("bad_slot_idle", int'(busy), 0);

    // overlong and short entries
    e0 = n_err;
    send("5551166#", 1);
    check("overlong_err", n_err - e0, 1);
    check("overlong_fail", int'(fail_count), 1);
    send("55#", 0);
    idle(1);
    check("short_err", n_err - e0, 2);
    check("short_fail", int'(fail_count), 2);

    // inactivity timeout
    send("555116#", 1);
    e0 = n_err; u0 = n_unl; p0 = n_prog;
    send("123", 1);
    idle(TMO_CYC - 3);
    check("tmo_busy_before", int'(busy), 1);
    idle(5);
    check("tmo_busy_after", int'(busy), 0);
    check("tmo_no_evt", (n_err - e0) + (n_unl - u0) + (n_prog - p0), 0);

    // reset in the middle of PROG_NEW invalidates slots
    send("555116#", 1);
    send("*212", 1);
    check("prog_mode_hi", int'(prog_mode), 1);
    do_reset(1);
    check("mid_rst_locked", int'(locked), 1);
    check("mid_rst_prog", int'(prog_mode), 0);
    check("mid_rst_busy", int'(busy), 0);
    idle(1);
    e0 = n_err;
    send("666666#", 1);
    check("slot_cleared_by_rst", n_err - e0, 1);
    check("slot_cleared_locked", int'(locked), 1);

    // randomized traffic against the model
    for (int w = 0; w < 300; w++) begin
      int r, g;
      string s, c;
      r = $urandom_range(0, 9);
      g = $urandom_range(0, 1);
      case (r)
        0, 1, 2: send("555116#", g);
        3:       send({rand_code(), "#"}, g);
        4: begin
          c = rand_code();
          s = {"*", $sformatf("%0d", $urandom_range(0, 4)), c, "#"};
          if ($urandom_range(0, 3) == 0) s = {s, rand_code(), "#"};
          else                           s = {s, c, "#"};
          send(s, g);
        end
        5: for (int i = 0; i < int'($urandom_range(1, 8)); i++)
             press(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        6: idle(int'($urandom_range(0, 80)));
        7: begin
          s = "*";
          for (int i = 0; i < int'($urandom_range(0, 4)); i++)
            s = {s, $sformatf("%0d", $urandom_range(0, 9))};
          send({s, "*"}, g);
        end
        8: begin
          s = "";
          for (int i = 0; i < int'($urandom_range(0, 8)); i++)
            s = {s, $sformatf("%0d", $urandom_range(0, 9))};
          send({s, "#"}, g);
        end
        default: if ($urandom_range(0, 3) == 0) do_reset(2);
                 else send("*0#", g);
      endcase
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
